// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue
//   Checkpointed FIFO between the FE PC generator and the backend issue logic.
//   Packets are written at wptr, consumed speculatively at rptr and committed
//   at cptr. The backend can replay consumed-but-uncommitted packets (roll) or
//   discard everything (clr) on a redirect.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   fe_queue_i/_v_i     packet in from pc_gen, handshaked with fe_queue_ready_o
//   fe_queue_o/_v_o     packet at the speculative read pointer
//   fe_queue_yumi_i     backend consumes fe_queue_o (rptr++)
//   fe_queue_deq_i      commit oldest consumed entry (cptr++)
//   fe_queue_roll_i     replay from the commit point (rptr <= cptr)
//   fe_queue_clr_i      discard all entries
//   count_o             committed occupancy (wptr - cptr)
//   almost_full_o       occupancy >= els_p - almost_full_margin_p
//
// Build option
//   BP_FE_QUEUE_BYPASS_EN: when defined, a packet written into an empty queue
//   is visible on fe_queue_o in the same cycle. Otherwise write-to-visible
//   latency is one cycle and there is no combinational in->out path.

module bp_fe_fetch_queue #(
  parameter int els_p                = 8,
  parameter int data_width_p         = 160,
  parameter int almost_full_margin_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [data_width_p-1:0] fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [data_width_p-1:0] fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    fe_queue_deq_i,
  input  logic                    fe_queue_roll_i,
  input  logic                    fe_queue_clr_i,
  output logic [$clog2(els_p):0]  count_o,
  output logic                    almost_full_o
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] one_lp       = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] els_lp       = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] af_thresh_lp = ptr_width_lp'(els_p - almost_full_margin_p);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;

  logic [data_width_p-1:0] mem_q [els_p];

  logic [ptr_width_lp-1:0] occupancy;
  logic                    full;
  logic                    empty;
  logic                    write_en;

  assign occupancy = wptr_q - cptr_q;
  assign full      = (occupancy == els_lp);
  assign empty     = (rptr_q == wptr_q);

  // Ready looks only at registered pointers: a same-cycle deq does not make
  // room, and clr does not mask it (the packet is accepted and dropped).
  assign fe_queue_ready_o = ~reset_i & ~full;
  assign write_en         = fe_queue_v_i & fe_queue_ready_o;

  // Status outputs are forced to their idle values while reset is held so the
  // consumer never sees stale state during a mid-stream reset.
  assign count_o       = reset_i ? '0 : occupancy;
  assign almost_full_o = ~reset_i & (occupancy >= af_thresh_lp);

`ifdef BP_FE_QUEUE_BYPASS_EN
  // Empty queue with an accepted write: forward the incoming packet directly.
  // The entry is still written, so a same-cycle yumi leaves it replayable.
  assign fe_queue_v_o = ~reset_i & (~empty | (write_en & ~fe_queue_clr_i));
  assign fe_queue_o   = empty ? fe_queue_i : mem_q[rptr_q[idx_width_lp-1:0]];
`else
  assign fe_queue_v_o = ~reset_i & ~empty;
  assign fe_queue_o   = mem_q[rptr_q[idx_width_lp-1:0]];
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (fe_queue_clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cptr_d = '0;
    end else begin
      if (write_en) begin
        wptr_d = wptr_q + one_lp;
      end
      if (fe_queue_deq_i) begin
        cptr_d = cptr_q + one_lp;
      end
      // Roll rewinds to the commit point after this cycle's deq and
      // overrides any same-cycle yumi.
      if (fe_queue_roll_i) begin
        rptr_d = cptr_d;
      end else if (fe_queue_yumi_i) begin
        rptr_d = rptr_q + one_lp;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Packet storage is deliberately not reset; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (write_en & ~fe_queue_clr_i) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: consuming with nothing visible, or committing an entry
  // that has not been consumed yet, is a backend bug.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!fe_queue_yumi_i || fe_queue_v_o);
      assert (!fe_queue_deq_i || (cptr_q != rptr_q));
    end
  end
`endif

endmodule
